// File: rtl/ov7670_marker_tracker_if.sv
// Camera pin bundle plus frame-buffer write port (BRAM port A) for the marker tracker.
// The tracker takes the slave side; the camera/BRAM environment takes the master side.
interface ov7670_marker_tracker_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dout;
    logic              we;

    modport master (output vsync, href, d, input addr, dout, we);
    modport slave  (input vsync, href, d, output addr, dout, we);
endinterface

// File: rtl/ov7670_marker_tracker.sv
// OV7670 RGB565 capture into the frame buffer with calibration-box overlay, reference-colour
// learning and per-frame colour-marker centroid tracking with exponential smoothing.
module ov7670_marker_tracker #(
    parameter int unsigned H_ACT    = 320,
    parameter int unsigned V_ACT    = 240,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned CAL_X0   = 150,
    parameter int unsigned CAL_Y0   = 110,
    parameter int unsigned CAL_WL2  = 4,
    parameter int unsigned CAL_HL2  = 4,
    parameter int unsigned TOL_R    = 2,
    parameter int unsigned TOL_G    = 4,
    parameter int unsigned TOL_B    = 2,
    parameter int unsigned MIN_PIX  = 32,
    parameter int unsigned ALPHA_SH = 3,
    parameter logic [15:0] MARK_COL = 16'hF800
) (
    input  logic                     pclk,
    input  logic                     resetn,
    ov7670_marker_tracker_if.slave   cam,
    input  logic                     calibration,
    output logic [15:0]              ref_rgb,
    output logic [$clog2(H_ACT)-1:0] cx,
    output logic [$clog2(V_ACT)-1:0] cy,
    output logic [$clog2(H_ACT)-1:0] cx_s,
    output logic [$clog2(V_ACT)-1:0] cy_s,
    output logic [ADDR_W-1:0]        match_cnt,
    output logic                     lost,
    output logic                     cen_valid
);
    localparam int unsigned XW    = $clog2(H_ACT);
    localparam int unsigned YW    = $clog2(V_ACT);
    localparam int unsigned MW    = (XW > YW) ? XW : YW;
    localparam int unsigned DW    = ADDR_W + MW;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam int unsigned SXW   = ADDR_W + XW;
    localparam int unsigned SYW   = ADDR_W + YW;
    localparam int unsigned SH    = CAL_WL2 + CAL_HL2;
    localparam int unsigned RW    = 6 + SH;
    localparam int unsigned DCW   = $clog2(DW + 1);
    localparam int unsigned TOTAL = H_ACT * V_ACT;
    localparam int          X0    = CAL_X0;
    localparam int          Y0    = CAL_Y0;
    localparam int          WIN_W = 1 << CAL_WL2;
    localparam int          WIN_H = 1 << CAL_HL2;
    localparam logic [CW-1:0]     TOTAL_C   = CW'(TOTAL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    typedef enum logic [1:0] {StWaitFrame, StCapture, StDivide, StUpdate} state_t;

    state_t          state_q;
    logic            vsync_q, href_q, phase_q, mode_q, have_cen_q;
    logic [7:0]      hi_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   pix_q, cnt_q, den_q;
    logic [SXW-1:0]  sum_x_q;
    logic [SYW-1:0]  sum_y_q;
    logic [RW-1:0]   sum_r_q, sum_g_q, sum_b_q;
    logic [DW-1:0]   num_x_q, num_y_q;
    logic [CW-1:0]   rem_x_q, rem_y_q;
    logic [DCW-1:0]  dcnt_q;

    logic            vsync_rise, vsync_fall, href_fall, px_done, in_frame;
    logic            in_win, on_border, match;
    logic [15:0]     px;
    logic [4:0]      dr, db;
    logic [5:0]      dg;
    int              xi, yi;
    logic [CW:0]     rem_x_sh, rem_y_sh, rem_x_n, rem_y_n;
    logic            ge_x, ge_y;
    logic signed [XW:0] dx, step_x;
    logic signed [YW:0] dy, step_y;
    logic [RW-1:0]   avg_r, avg_g, avg_b;

    always_comb begin
        vsync_rise = cam.vsync & ~vsync_q;
        vsync_fall = ~cam.vsync & vsync_q;
        href_fall  = ~cam.href & href_q;
        px_done    = (state_q == StCapture) && cam.href && phase_q;
        in_frame   = pix_q < TOTAL_C;
        px         = {hi_q, cam.d};

        dr = (px[15:11] > ref_rgb[15:11]) ? px[15:11] - ref_rgb[15:11] : ref_rgb[15:11] - px[15:11];
        dg = (px[10:5] > ref_rgb[10:5]) ? px[10:5] - ref_rgb[10:5] : ref_rgb[10:5] - px[10:5];
        db = (px[4:0] > ref_rgb[4:0]) ? px[4:0] - ref_rgb[4:0] : ref_rgb[4:0] - px[4:0];
        match = (dr <= 5'(TOL_R)) && (dg <= 6'(TOL_G)) && (db <= 5'(TOL_B));

        xi        = int'(x_q);
        yi        = int'(y_q);
        in_win    = (xi >= X0) && (xi < X0 + WIN_W) && (yi >= Y0) && (yi < Y0 + WIN_H);
        on_border = !in_win && (xi >= X0 - 1) && (xi <= X0 + WIN_W) &&
                    (yi >= Y0 - 1) && (yi <= Y0 + WIN_H);

        // Restoring divider step: shift in the next dividend bit, subtract if it fits.
        rem_x_sh = {rem_x_q, num_x_q[DW-1]};
        rem_y_sh = {rem_y_q, num_y_q[DW-1]};
        ge_x     = rem_x_sh >= {1'b0, den_q};
        ge_y     = rem_y_sh >= {1'b0, den_q};
        rem_x_n  = ge_x ? rem_x_sh - {1'b0, den_q} : rem_x_sh;
        rem_y_n  = ge_y ? rem_y_sh - {1'b0, den_q} : rem_y_sh;

        dx     = $signed({1'b0, num_x_q[XW-1:0]}) - $signed({1'b0, cx_s});
        dy     = $signed({1'b0, num_y_q[YW-1:0]}) - $signed({1'b0, cy_s});
        step_x = dx >>> ALPHA_SH;
        step_y = dy >>> ALPHA_SH;

        avg_r = sum_r_q >> SH;
        avg_g = sum_g_q >> SH;
        avg_b = sum_b_q >> SH;
    end

    logic unused;
    assign unused = ^{rem_x_n[CW], rem_y_n[CW], step_x[XW], step_y[YW],
                      avg_r[RW-1:5], avg_g[RW-1:6], avg_b[RW-1:5]};

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StWaitFrame;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            phase_q    <= 1'b0;
            mode_q     <= 1'b0;
            have_cen_q <= 1'b0;
            hi_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            pix_q      <= '0;
            cnt_q      <= '0;
            den_q      <= '0;
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            sum_r_q    <= '0;
            sum_g_q    <= '0;
            sum_b_q    <= '0;
            num_x_q    <= '0;
            num_y_q    <= '0;
            rem_x_q    <= '0;
            rem_y_q    <= '0;
            dcnt_q     <= '0;
            cam.addr   <= '0;
            cam.dout   <= '0;
            cam.we     <= 1'b0;
            ref_rgb    <= '0;
            cx         <= '0;
            cy         <= '0;
            cx_s       <= '0;
            cy_s       <= '0;
            match_cnt  <= '0;
            lost       <= 1'b1;
            cen_valid  <= 1'b0;
        end else begin
            vsync_q   <= cam.vsync;
            href_q    <= cam.href;
            cam.we    <= 1'b0;
            cen_valid <= 1'b0;

            if (!cam.href) begin
                phase_q <= 1'b0;
            end else begin
                phase_q <= ~phase_q;
                if (!phase_q) hi_q <= cam.d;
            end

            unique case (state_q)
                StWaitFrame: begin
                    if (vsync_fall) begin
                        mode_q  <= calibration;
                        x_q     <= '0;
                        y_q     <= '0;
                        pix_q   <= '0;
                        cnt_q   <= '0;
                        sum_x_q <= '0;
                        sum_y_q <= '0;
                        sum_r_q <= '0;
                        sum_g_q <= '0;
                        sum_b_q <= '0;
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    if (px_done) begin
                        x_q <= x_q + XW'(1);
                        if (in_frame) begin
                            cam.we   <= 1'b1;
                            cam.addr <= pix_q[ADDR_W-1:0];
                            pix_q    <= pix_q + CW'(1);
                            if (mode_q) begin
                                cam.dout <= on_border ? 16'h0000 : px;
                                if (in_win) begin
                                    sum_r_q <= sum_r_q + RW'(px[15:11]);
                                    sum_g_q <= sum_g_q + RW'(px[10:5]);
                                    sum_b_q <= sum_b_q + RW'(px[4:0]);
                                end
                            end else begin
                                cam.dout <= match ? MARK_COL : 16'h0000;
                                if (match) begin
                                    sum_x_q <= sum_x_q + SXW'(x_q);
                                    sum_y_q <= sum_y_q + SYW'(y_q);
                                    cnt_q   <= cnt_q + CW'(1);
                                end
                            end
                        end else begin
                            cam.addr <= LAST_ADDR;
                        end
                    end
                    if (href_fall) begin
                        x_q <= '0;
                        y_q <= y_q + YW'(1);
                    end
                    if (vsync_rise) begin
                        if (pix_q == TOTAL_C) begin
                            // Snapshot so a new frame cannot disturb the division.
                            num_x_q <= DW'(sum_x_q);
                            num_y_q <= DW'(sum_y_q);
                            den_q   <= cnt_q;
                            rem_x_q <= '0;
                            rem_y_q <= '0;
                            dcnt_q  <= '0;
                            state_q <= StDivide;
                        end else begin
                            state_q <= StWaitFrame;
                        end
                    end
                end
                StDivide: begin
                    rem_x_q <= rem_x_n[CW-1:0];
                    rem_y_q <= rem_y_n[CW-1:0];
                    num_x_q <= {num_x_q[DW-2:0], ge_x};
                    num_y_q <= {num_y_q[DW-2:0], ge_y};
                    dcnt_q  <= dcnt_q + DCW'(1);
                    if (dcnt_q == DCW'(DW - 1)) state_q <= StUpdate;
                end
                StUpdate: begin
                    if (mode_q) begin
                        ref_rgb <= {avg_r[4:0], avg_g[5:0], avg_b[4:0]};
                    end else begin
                        match_cnt <= cnt_q[ADDR_W-1:0];
                        if (cnt_q < CW'(MIN_PIX)) begin
                            lost <= 1'b1;
                        end else begin
                            lost      <= 1'b0;
                            cx        <= num_x_q[XW-1:0];
                            cy        <= num_y_q[YW-1:0];
                            cen_valid <= 1'b1;
                            if (have_cen_q) begin
                                cx_s <= cx_s + step_x[XW-1:0];
                                cy_s <= cy_s + step_y[YW-1:0];
                            end else begin
                                cx_s       <= num_x_q[XW-1:0];
                                cy_s       <= num_y_q[YW-1:0];
                                have_cen_q <= 1'b1;
                            end
                        end
                    end
                    state_q <= StWaitFrame;
                end
                default: state_q <= StWaitFrame;
            endcase
        end
    end
endmodule

// File: tb/tb_ov7670_marker_tracker.sv
// Directed bench for ov7670_marker_tracker on a reduced 48x24 frame with a 4x4 calibration
// window; frame-buffer writes and centroid pulses are checked against scoreboard queues.
module tb_ov7670_marker_tracker;
    localparam int H   = 48;
    localparam int V   = 24;
    localparam int AW  = 11;
    localparam int X0  = 8;
    localparam int Y0  = 4;
    localparam int WW  = 4;
    localparam int WH  = 4;
    localparam int SH  = 4;

    logic       pclk;
    logic       resetn;
    logic       calibration;
    logic [15:0] ref_rgb;
    logic [5:0] cx, cx_s;
    logic [4:0] cy, cy_s;
    logic [AW-1:0] match_cnt;
    logic       lost;
    logic       cen_valid;

    ov7670_marker_tracker_if #(.ADDR_W(AW)) cam ();

    ov7670_marker_tracker #(
        .H_ACT  (H),
        .V_ACT  (V),
        .ADDR_W (AW),
        .CAL_X0 (X0),
        .CAL_Y0 (Y0),
        .CAL_WL2(2),
        .CAL_HL2(2)
    ) dut (
        .pclk       (pclk),
        .resetn     (resetn),
        .cam        (cam),
        .calibration(calibration),
        .ref_rgb    (ref_rgb),
        .cx         (cx),
        .cy         (cy),
        .cx_s       (cx_s),
        .cy_s       (cy_s),
        .match_cnt  (match_cnt),
        .lost       (lost),
        .cen_valid  (cen_valid)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;

    logic [26:0] wr_q[$];
    logic [21:0] cen_q[$];
    logic [26:0] exp_wr;
    logic [21:0] exp_cen;

    // Model state
    logic [15:0] ref_m;
    int mcnt_m, cx_m, cy_m, cxs_m, cys_m;
    bit lost_m, have_m;

    always @(negedge pclk) begin
        if (cam.we) begin
            wr_seen++;
            checks++;
            assert (wr_q.size() != 0) else begin
                errors++;
                $error("FAIL wr_unexpected: got addr=%0d dout=%h, required no write",
                       cam.addr, cam.dout);
            end
            if (wr_q.size() != 0) begin
                exp_wr = wr_q.pop_front();
                checks++;
                assert ({cam.addr, cam.dout} === exp_wr) else begin
                    errors++;
                    $error("FAIL wr: got addr=%0d dout=%h, required addr=%0d dout=%h",
                           cam.addr, cam.dout, exp_wr[26:16], exp_wr[15:0]);
                end
            end
        end
        if (cen_valid) begin
            checks++;
            assert (cen_q.size() != 0) else begin
                errors++;
                $error("FAIL cen_unexpected: got cx=%0d cy=%0d, required no pulse", cx, cy);
            end
            if (cen_q.size() != 0) begin
                exp_cen = cen_q.pop_front();
                checks++;
                assert ({cx, cy, cx_s, cy_s} === exp_cen) else begin
                    errors++;
                    $error("FAIL cen: got %0d,%0d s %0d,%0d required %0d,%0d s %0d,%0d",
                           cx, cy, cx_s, cy_s, exp_cen[21:16], exp_cen[15:11],
                           exp_cen[10:5], exp_cen[4:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_match(input logic [15:0] p);
        int dr, dg, db;
        dr = int'(p[15:11]) - int'(ref_m[15:11]);
        dg = int'(p[10:5]) - int'(ref_m[10:5]);
        db = int'(p[4:0]) - int'(ref_m[4:0]);
        if (dr < 0) dr = -dr;
        if (dg < 0) dg = -dg;
        if (db < 0) db = -db;
        return (dr <= 2) && (dg <= 4) && (db <= 2);
    endfunction

    task automatic model_reset();
        ref_m = 16'h0000;
        mcnt_m = 0; cx_m = 0; cy_m = 0; cxs_m = 0; cys_m = 0;
        lost_m = 1'b1;
        have_m = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ref"}, ref_rgb, ref_m);
        chk({tag, "_mcnt"}, match_cnt, mcnt_m);
        chk({tag, "_lost"}, lost, lost_m);
        chk({tag, "_cx"}, cx, cx_m);
        chk({tag, "_cy"}, cy, cy_m);
        chk({tag, "_cxs"}, cx_s, cxs_m);
        chk({tag, "_cys"}, cy_s, cys_m);
        chk({tag, "_wrq"}, wr_q.size(), 0);
        chk({tag, "_cenq"}, cen_q.size(), 0);
    endtask

    // Drives one frame (vsync is high on entry and on exit) and pushes expected writes.
    task automatic run_frame(input bit cal, input logic [15:0] pcol, input int px0,
                             input int py0, input int npix, input bit commit);
        int idx, cnt, sx, sy, sr, sg, sb, w0;
        logic [15:0] p, e;
        bit in_win, near;
        idx = 0; cnt = 0; sx = 0; sy = 0; sr = 0; sg = 0; sb = 0;
        w0 = wr_seen;
        calibration = cal;
        repeat (30) step();
        cam.vsync = 1'b0;
        repeat (4) step();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (idx < npix) begin
                    if (cal) p = 16'h8410;
                    else if (x >= px0 && x < px0 + 10 && y >= py0 && y < py0 + 10) p = pcol;
                    else p = 16'h0000;
                    if (cal) begin
                        in_win = x >= X0 && x < X0 + WW && y >= Y0 && y < Y0 + WH;
                        near = x >= X0 - 1 && x <= X0 + WW && y >= Y0 - 1 && y <= Y0 + WH;
                        e = (near && !in_win) ? 16'h0000 : p;
                        if (in_win) begin
                            sr += int'(p[15:11]);
                            sg += int'(p[10:5]);
                            sb += int'(p[4:0]);
                        end
                    end else if (model_match(p)) begin
                        e = 16'hF800;
                        cnt++;
                        sx += x;
                        sy += y;
                    end else begin
                        e = 16'h0000;
                    end
                    wr_q.push_back({idx[AW-1:0], e});
                    cam.href = 1'b1;
                    cam.d = p[15:8];
                    step();
                    cam.d = p[7:0];
                    step();
                    idx++;
                end
            end
            cam.href = 1'b0;
            cam.d = 8'h00;
            repeat (4) step();
        end
        cam.vsync = 1'b1;
        chk("nwrites", wr_seen - w0, npix);
        if (commit && idx == H * V) begin
            if (cal) begin
                ref_m = {5'(sr >> SH), 6'(sg >> SH), 5'(sb >> SH)};
            end else begin
                mcnt_m = cnt;
                if (cnt < 32) begin
                    lost_m = 1'b1;
                end else begin
                    lost_m = 1'b0;
                    cx_m = sx / cnt;
                    cy_m = sy / cnt;
                    if (have_m) begin
                        cxs_m = cxs_m + ((cx_m - cxs_m) >>> 3);
                        cys_m = cys_m + ((cy_m - cys_m) >>> 3);
                    end else begin
                        cxs_m = cx_m;
                        cys_m = cy_m;
                        have_m = 1'b1;
                    end
                    cen_q.push_back({6'(cx_m), 5'(cy_m), 6'(cxs_m), 5'(cys_m)});
                end
            end
        end
    endtask

    initial begin
        cam.vsync = 1'b1;
        cam.href = 1'b0;
        cam.d = 8'h00;
        calibration = 1'b0;
        resetn = 1'b0;
        model_reset();
        repeat (3) step();
        check_state("reset");
        resetn = 1'b1;
        step();

        // Calibrate on a uniform frame
        run_frame(1'b1, 16'h0000, 0, 0, H * V, 1'b1);
        repeat (40) step();
        check_state("cal");
        chk("cal_ref_lit", ref_rgb, 16'h8410);

        // Track a 10x10 near-reference patch
        run_frame(1'b0, 16'h8411, 30, 6, H * V, 1'b1);
        repeat (40) step();
        check_state("track1");
        chk("track1_cx_lit", cx, 34);
        chk("track1_cy_lit", cy, 10);
        chk("track1_mcnt_lit", match_cnt, 100);
        chk("track1_lost_lit", lost, 0);

        // Red one step beyond tolerance: nothing matches
        run_frame(1'b0, 16'h9C10, 30, 6, H * V, 1'b1);
        repeat (40) step();
        check_state("thresh");
        chk("thresh_mcnt_lit", match_cnt, 0);
        chk("thresh_lost_lit", lost, 1);

        // Second valid centroid moves left; smoothing steps by floor(-28/8)
        run_frame(1'b0, 16'h8411, 2, 6, H * V, 1'b1);
        repeat (40) step();
        check_state("smooth");
        chk("smooth_cxs_lit", cx_s, 30);

        // Short frame is dropped
        run_frame(1'b0, 16'h8411, 20, 0, 1000, 1'b1);
        repeat (40) step();
        check_state("short");

        // Next full frame processed normally
        run_frame(1'b0, 16'h8411, 30, 14, H * V, 1'b1);
        repeat (40) step();
        check_state("after_short");
        chk("after_short_cys_lit", cy_s, 11);

        // Reset asserted while dividing
        run_frame(1'b0, 16'h8411, 30, 6, H * V, 1'b0);
        repeat (6) step();
        resetn = 1'b0;
        #1;
        model_reset();
        check_state("reset_div");
        step();
        resetn = 1'b1;
        step();
        check_state("post_reset");

        run_frame(1'b1, 16'h0000, 0, 0, H * V, 1'b1);
        repeat (40) step();
        check_state("recal");
        run_frame(1'b0, 16'h8411, 30, 6, H * V, 1'b1);
        repeat (40) step();
        check_state("reload");
        chk("reload_cxs_lit", cx_s, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
